trade_order_gen: RTL and testbench
==================================

# trade_order_gen

Order-generation stage downstream of the mean-reversion signal unit. It consumes the registered buy/sell decision and its valid strobe, and enforces a signed position limit and a post-trade cooldown. Accepted decisions become single orders presented on a valid/ready handshake to the order-egress logic. It is the receiving end of the signal interface and the originating end of the order interface.

## Interface
- MAX_POS, 8'sd4: absolute position limit in units; position is always within [-MAX_POS, +MAX_POS].
- ORDER_QTY, 8'd1: quantity per order; must be at least 1 and no greater than MAX_POS.
- COOLDOWN, 4'd3: idle cycles enforced after each completed order; 0 disables the cooldown.
- clk  in  1  single clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- data_valid_mean  in  1  buy_signal/sell_signal/current_data are valid this cycle.
- buy_signal  in  1  buy decision.
- sell_signal  in  1  sell decision.
- current_data  in  8  unsigned price aligned with the decision.
- order_ready  in  1  egress accepts the order this cycle.
- order_valid  out  1  order presented.
- order_side  out  1  1 = buy, 0 = sell.
- order_price  out  8  latched price.
- order_qty  out  8  equals ORDER_QTY while order_valid is high.
- position  out  8  signed two's-complement net position.
- dropped_cnt  out  8  saturating count of rejected decisions.
- busy  out  1  high in ISSUE or COOL.

## Operation
- FSM states: IDLE, ISSUE, COOL. Reset enters IDLE.
- A decision is a cycle with data_valid_mean=1 and buy_signal|sell_signal=1. Cycles with data_valid_mean=0 are ignored entirely.
- IDLE, accept condition: exactly one of buy_signal/sell_signal is high, and the limit permits the trade.
  - Buy permitted when position + ORDER_QTY <= MAX_POS.
  - Sell permitted when position - ORDER_QTY >= -MAX_POS.
  - Limit comparisons use 9-bit signed arithmetic, so they never wrap.
- IDLE, on accept: latch side and current_data, go to ISSUE.
- IDLE, a decision with both signals high (conflict) or a limit violation increments dropped_cnt; the state stays IDLE.
- ISSUE: order_valid=1. order_side, order_price and order_qty are held stable until the handshake.
- ISSUE, on handshake (order_valid & order_ready): position += ORDER_QTY for buy, or -= ORDER_QTY for sell. Then load the cooldown counter with COOLDOWN and go to COOL, or go straight to IDLE if COOLDOWN=0.
- ISSUE with order_ready=0 stays in ISSUE indefinitely; there is no timeout.
- COOL: the counter decrements each cycle; the state goes to IDLE on the cycle the counter reaches 1.
- Any decision seen in ISSUE or COOL increments dropped_cnt and is otherwise discarded; there is no queueing.
- dropped_cnt saturates at 8'hFF and never wraps.
- Reset, including mid-ISSUE or mid-COOL, abandons any pending order. Position is not updated and all registers return to reset values.

## Timing
- All outputs are registered.
- Reset values: order_valid=0, order_side=0, order_price=0, order_qty=0, position=0, dropped_cnt=0, busy=0, state=IDLE, counter=0.
- A decision accepted at edge N drives order_valid=1 from cycle N+1. Latency is 1 cycle.
- Handshake at edge M:
  - order_valid=0 and position updated from cycle M+1.
  - busy stays 1 through COOL.
  - The first new decision can be accepted at edge M+1+COOLDOWN.
- With COOLDOWN=0, a decision at edge M+1 is accepted, giving back-to-back orders one idle cycle apart.
- A decision arriving on the same edge as the handshake is dropped, because the state is ISSUE.
- dropped_cnt updates one cycle after the rejected decision.
- order_qty is 0 whenever order_valid=0.

## Test plan
- Reset, then buy at price 8'd50 with order_ready=1 -> order_valid high one cycle later with side=1, price=50, qty=1. Position reads 1 the cycle after, then busy for 3 cycles.
- Hold order_ready=0 for 5 cycles after a sell at price 8'd200 -> order_valid and payload stable for all 5 cycles. Release ready -> position=-1, single handshake.
- Five buys spaced beyond the cooldown with MAX_POS=4 -> four orders, position=4, fifth rejected with dropped_cnt=1. A following sell is accepted and position returns to 3.
- buy_signal and sell_signal both high with valid -> no order, dropped_cnt increments. Decision during COOL -> dropped, and the first decision at M+1+COOLDOWN is accepted.
- 300 conflicting decisions -> dropped_cnt holds at 255.
- Assert rst while in ISSUE with position=2 -> next cycle order_valid=0, position=0, state IDLE. No handshake is counted.

Source files
------------

// File: rtl/trade_order_gen.sv
// Order generator: turns buy/sell decisions into single handshaked orders while
// holding the net position inside +/-MAX_POS and spacing orders by a cooldown.
module trade_order_gen #(
  parameter logic signed [7:0] MAX_POS   = 8'sd4,
  parameter logic [7:0]        ORDER_QTY = 8'd1,
  parameter logic [3:0]        COOLDOWN  = 4'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_valid_mean,
  input  logic       buy_signal,
  input  logic       sell_signal,
  input  logic [7:0] current_data,
  input  logic       order_ready,
  output logic       order_valid,
  output logic       order_side,
  output logic [7:0] order_price,
  output logic [7:0] order_qty,
  output logic [7:0] position,
  output logic [7:0] dropped_cnt,
  output logic       busy,
  output logic [1:0] state_dbg
);

  // Order handshake: an order transfers on any rising edge where order_valid
  // and order_ready are both high; order_valid and its payload stay put until then.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    COOL  = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [3:0]        cool_cnt, cool_cnt_nx;
  logic              decision, one_side, buy_ok, sell_ok;
  logic              accept, drop, handshake;
  logic signed [8:0] pos_ext, max_ext, qty_ext, buy_sum, sell_diff;

  // Limit checks run one bit wider than the position so they cannot wrap.
  assign pos_ext   = {position[7], position};
  assign max_ext   = {MAX_POS[7], MAX_POS};
  assign qty_ext   = {1'b0, ORDER_QTY};
  assign buy_sum   = pos_ext + qty_ext;
  assign sell_diff = pos_ext - qty_ext;
  assign buy_ok    = (buy_sum <= max_ext);
  assign sell_ok   = (sell_diff >= -max_ext);

  assign decision  = data_valid_mean & (buy_signal | sell_signal);
  assign one_side  = buy_signal ^ sell_signal;
  assign state_dbg = state;

  always_comb begin
    state_nx    = state;
    cool_cnt_nx = cool_cnt;
    accept      = 1'b0;
    drop        = 1'b0;
    handshake   = 1'b0;
    case (state)
      IDLE: begin
        if (decision) begin
          if (one_side && (buy_signal ? buy_ok : sell_ok)) begin
            accept   = 1'b1;
            state_nx = ISSUE;
          end else begin
            drop = 1'b1;
          end
        end
      end
      ISSUE: begin
        drop = decision;
        if (order_ready) begin
          handshake = 1'b1;
          if (COOLDOWN == 4'd0) begin
            state_nx = IDLE;
          end else begin
            state_nx    = COOL;
            cool_cnt_nx = COOLDOWN;
          end
        end
      end
      COOL: begin
        drop        = decision;
        cool_cnt_nx = cool_cnt - 4'd1;
        if (cool_cnt <= 4'd1) begin
          state_nx    = IDLE;
          cool_cnt_nx = 4'd0;
        end
      end
      default: begin
        state_nx    = IDLE;
        cool_cnt_nx = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cool_cnt    <= 4'd0;
      order_valid <= 1'b0;
      order_side  <= 1'b0;
      order_price <= 8'd0;
      order_qty   <= 8'd0;
      position    <= 8'd0;
      dropped_cnt <= 8'd0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      cool_cnt    <= cool_cnt_nx;
      order_valid <= (state_nx == ISSUE);
      order_qty   <= (state_nx == ISSUE) ? ORDER_QTY : 8'd0;
      busy        <= (state_nx != IDLE);
      if (accept) begin
        order_side  <= buy_signal;
        order_price <= current_data;
      end
      if (handshake) begin
        position <= order_side ? (position + ORDER_QTY) : (position - ORDER_QTY);
      end
      if (drop && (dropped_cnt != 8'hFF)) begin
        dropped_cnt <= dropped_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_trade_order_gen.sv
// Bench for trade_order_gen: directed scenarios plus random traffic, checked
// every cycle against a time-based model of positions, cooldown windows and drops.
module tb_trade_order_gen;

  localparam int MAX_POS = 4;
  localparam int QTY     = 1;
  localparam int COOL    = 3;

  logic       clk;
  logic       rst;
  logic       data_valid_mean;
  logic       buy_signal;
  logic       sell_signal;
  logic [7:0] current_data;
  logic       order_ready;
  logic       order_valid;
  logic       order_side;
  logic [7:0] order_price;
  logic [7:0] order_qty;
  logic [7:0] position;
  logic [7:0] dropped_cnt;
  logic       busy;
  logic [1:0] state_dbg;

  trade_order_gen #(
    .MAX_POS  (8'sd4),
    .ORDER_QTY(8'd1),
    .COOLDOWN (4'd3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_valid_mean(data_valid_mean),
    .buy_signal     (buy_signal),
    .sell_signal    (sell_signal),
    .current_data   (current_data),
    .order_ready    (order_ready),
    .order_valid    (order_valid),
    .order_side     (order_side),
    .order_price    (order_price),
    .order_qty      (order_qty),
    .position       (position),
    .dropped_cnt    (dropped_cnt),
    .busy           (busy),
    .state_dbg      (state_dbg)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: orders are pending or not; cooldown is a cycle index
  // before which no new decision is accepted
  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;
  int m_pos    = 0;
  int m_drop   = 0;
  bit m_pending = 0;
  bit m_side    = 0;
  int m_price   = 0;
  int m_free_at = 0;

  task automatic model_edge(input logic dv, input logic b, input logic s,
                            input logic [7:0] p, input logic rdy);
    bit dec;
    edge_n++;
    if (rst) begin
      m_pos = 0; m_drop = 0; m_pending = 0; m_side = 0; m_price = 0; m_free_at = 0;
      return;
    end
    dec = dv && (b || s);
    if (m_pending) begin
      if (dec) m_drop++;
      if (rdy) begin
        m_pos     = m_side ? m_pos + QTY : m_pos - QTY;
        m_pending = 0;
        m_free_at = edge_n + 1 + COOL;
      end
    end else if (edge_n < m_free_at) begin
      if (dec) m_drop++;
    end else if (dec) begin
      if ((b != s) && ((b && (m_pos + QTY <= MAX_POS)) || (s && (m_pos - QTY >= -MAX_POS)))) begin
        m_pending = 1;
        m_side    = b;
        m_price   = p;
      end else begin
        m_drop++;
      end
    end
    if (m_drop > 255) m_drop = 255;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic check_outputs();
    logic [7:0] pos8;
    pos8 = 8'(m_pos);
    check("order_valid", {31'd0, order_valid}, {31'd0, m_pending});
    check("order_side",  {31'd0, order_side},  {31'd0, m_side});
    check("order_price", {24'd0, order_price}, 32'(m_price));
    check("order_qty",   {24'd0, order_qty},   m_pending ? 32'(QTY) : 32'd0);
    check("position",    {24'd0, position},    {24'd0, pos8});
    check("dropped_cnt", {24'd0, dropped_cnt}, 32'(m_drop));
    check("busy",        {31'd0, busy},        (m_pending || (edge_n + 1 < m_free_at)) ? 32'd1 : 32'd0);
  endtask

  // driver: apply inputs, advance one edge, update model, compare
  task automatic step(input logic dv, input logic b, input logic s,
                      input logic [7:0] p, input logic rdy);
    data_valid_mean = dv;
    buy_signal      = b;
    sell_signal     = s;
    current_data    = p;
    order_ready     = rdy;
    @(posedge clk);
    model_edge(dv, b, s, p, rdy);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'd0, rdy);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    data_valid_mean = 1'b0;
    buy_signal = 1'b0;
    sell_signal = 1'b0;
    current_data = 8'd0;
    order_ready = 1'b0;

    // reset state
    do_reset(2);
    check("rst_state", {30'd0, state_dbg}, 32'd0);

    // buy at 50 with ready high
    step(1'b1, 1'b1, 1'b0, 8'd50, 1'b1);
    check("buy_valid", {31'd0, order_valid}, 32'd1);
    check("buy_price", {24'd0, order_price}, 32'd50);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    check("buy_pos", {24'd0, position}, 32'd1);
    idle(4, 1'b1);

    // sell at 200 held off by ready low for 5 cycles
    do_reset(1);
    step(1'b1, 1'b0, 1'b1, 8'd200, 1'b0);
    idle(5, 1'b0);
    check("sell_hold_price", {24'd0, order_price}, 32'd200);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    check("sell_pos", {24'd0, position}, 32'hFF);
    idle(5, 1'b1);

    // position limit: five buys, fifth rejected, then a sell
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'(10 + i), 1'b1);
      idle(5, 1'b1);
    end
    check("limit_pos", {24'd0, position}, 32'd4);
    check("limit_drop", {24'd0, dropped_cnt}, 32'd1);
    step(1'b1, 1'b0, 1'b1, 8'd99, 1'b1);
    idle(5, 1'b1);
    check("limit_sell_pos", {24'd0, position}, 32'd3);

    // conflict, then decision during cooldown, then first allowed decision
    step(1'b1, 1'b1, 1'b1, 8'd7, 1'b1);
    check("conflict_drop", {24'd0, dropped_cnt}, 32'd2);
    step(1'b1, 1'b1, 1'b0, 8'd60, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 8'd61, 1'b1);
    idle(2, 1'b1);
    step(1'b1, 1'b0, 1'b1, 8'd77, 1'b0);
    check("cool_edge_accept", {31'd0, order_valid}, 32'd1);
    check("cool_drop", {24'd0, dropped_cnt}, 32'd3);
    idle(5, 1'b1);

    // saturation of the drop counter
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b1, 8'($urandom), 1'b1);
    check("drop_sat", {24'd0, dropped_cnt}, 32'd255);

    // reset while an order is pending
    do_reset(1);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'd30, 1'b1);
      idle(5, 1'b1);
    end
    step(1'b1, 1'b1, 1'b0, 8'd31, 1'b0);
    idle(2, 1'b0);
    check("pre_rst_pos", {24'd0, position}, 32'd2);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    rst = 1'b0;
    check("rst_issue_valid", {31'd0, order_valid}, 32'd0);
    check("rst_issue_pos", {24'd0, position}, 32'd0);
    check("rst_issue_state", {30'd0, state_dbg}, 32'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0));
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
